// File: rtl/calc_pkg.sv
// Shared calculator types: opcodes and accumulator FSM states.
// Also used by the operand-entry stage upstream.
package calc_pkg;
  localparam int CALC_N = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2,
    CLR  = 2'd3
  } calc_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } calc_state_e;
endpackage

// File: rtl/calc_accumulator_if.sv
// Request/response handshake bundle of the accumulator stage.
interface calc_accumulator_if
  import calc_pkg::*;
#(
  parameter int N = CALC_N
);
  logic          in_valid;
  logic          in_ready;
  calc_op_e      in_op;
  logic [N-1:0]  in_operand;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_c;
  logic          out_v;
  logic          out_z;

  modport master (
    output in_valid, in_op, in_operand, out_ready,
    input  in_ready, out_valid, out_data, out_c, out_v, out_z
  );

  modport slave (
    input  in_valid, in_op, in_operand, out_ready,
    output in_ready, out_valid, out_data, out_c, out_v, out_z
  );
endinterface

// File: rtl/calc_flag_gen.sv
// Next accumulator value and C/V/Z flags from the adder result.
// CALC_ACC_SAT_EN: clamp ADD overflow to all-ones and SUB borrow to zero.
module calc_flag_gen
  import calc_pkg::*;
#(
  parameter int N = CALC_N
) (
  input  calc_op_e     op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] sum,
  input  logic         carry_out,
  output logic [N-1:0] acc_nxt,
  output logic         c,
  output logic         v,
  output logic         z
);
  // b is already inverted for SUB, so one overflow formula covers both
  logic ovf;
  assign ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);

  always_comb begin
    acc_nxt = '0;
    c       = 1'b0;
    v       = 1'b0;
    case (op)
      LOAD: acc_nxt = b;
      ADD: begin
        acc_nxt = sum;
        c       = carry_out;
        v       = ovf;
`ifdef CALC_ACC_SAT_EN
        if (carry_out) acc_nxt = '1;
`endif
      end
      SUB: begin
        acc_nxt = sum;
        c       = ~carry_out;
        v       = ovf;
`ifdef CALC_ACC_SAT_EN
        if (!carry_out) acc_nxt = '0;
`endif
      end
      default: acc_nxt = '0;
    endcase
    z = (acc_nxt == '0);
  end
endmodule

// File: rtl/calc_accumulator.sv
// Accumulator stage behind the external ripple adder: IDLE -> EXEC -> RESP.
// Saturating build selected by CALC_ACC_SAT_EN (see calc_flag_gen).
module calc_accumulator
  import calc_pkg::*;
#(
  parameter int N = CALC_N
) (
  input  logic          clk,
  input  logic          rst,
  calc_accumulator_if.slave bus,
  output logic [N-1:0]  A,
  output logic [N-1:0]  B,
  output logic          Carry_in,
  input  logic [N-1:0]  Sum,
  input  logic          Carry_out
);
  calc_state_e  state, state_nxt;
  calc_op_e     op_q;
  logic [N-1:0] operand_q, acc_q;
  logic         c_q, v_q, z_q;

  logic [N-1:0] acc_nxt;
  logic         c_nxt, v_nxt, z_nxt;

  assign A        = acc_q;
  assign B        = (op_q == SUB) ? ~operand_q : operand_q;
  assign Carry_in = (op_q == SUB);

  calc_flag_gen #(.N(N)) u_flag_gen (
    .op        (op_q),
    .a         (A),
    .b         (B),
    .sum       (Sum),
    .carry_out (Carry_out),
    .acc_nxt   (acc_nxt),
    .c         (c_nxt),
    .v         (v_nxt),
    .z         (z_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= LOAD;
      operand_q <= '0;
      acc_q     <= '0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        op_q      <= bus.in_op;
        operand_q <= bus.in_operand;
      end
      if (state == EXEC) begin
        acc_q <= acc_nxt;
        c_q   <= c_nxt;
        v_q   <= v_nxt;
        z_q   <= z_nxt;
      end
    end
  end

  // in_ready is gated by rst so nothing looks acceptable during reset
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == RESP);
  assign bus.out_data  = acc_q;
  assign bus.out_c     = c_q;
  assign bus.out_v     = v_q;
  assign bus.out_z     = z_q;
endmodule

// File: tb/tb_calc_accumulator.sv
// Bench for calc_accumulator: behavioural adder + arithmetic reference model.
module tb_calc_accumulator;
  import calc_pkg::*;

  localparam int N = 8;
`ifdef CALC_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_accumulator_if #(.N(N)) bus ();
  logic [N-1:0] A, B, Sum;
  logic         Carry_in, Carry_out;

  assign {Carry_out, Sum} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Carry_in};

  calc_accumulator #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .A         (A),
    .B         (B),
    .Carry_in  (Carry_in),
    .Sum       (Sum),
    .Carry_out (Carry_out)
  );

  int checks = 0;
  int errors = 0;
  logic [N-1:0] m_acc;

  // Reference: signed/unsigned integer arithmetic on the model accumulator
  task automatic model(input calc_op_e op, input logic [N-1:0] x,
                       output logic [N-1:0] d, output logic c, v, z);
    int a, b, s, sa, sb, ss;
    a = int'(m_acc); b = int'(x);
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    c = 1'b0; v = 1'b0; s = 0;
    case (op)
      LOAD: s = b;
      ADD: begin
        s = a + b; c = (s > 255); ss = sa + sb;
        v = (ss > 127) || (ss < -128);
        s = s % 256;
        if (SAT && c) s = 255;
      end
      SUB: begin
        c = (a < b); s = (a - b + 256) % 256; ss = sa - sb;
        v = (ss > 127) || (ss < -128);
        if (SAT && c) s = 0;
      end
      default: s = 0;
    endcase
    d = s[N-1:0];
    z = (s == 0);
    m_acc = d;
  endtask

  // Issues one op; lat = edges from request presentation to out_valid
  task automatic do_op(input calc_op_e op, input logic [N-1:0] x, input int hold,
                       output logic [N-1:0] d, output logic c, v, z, output int lat);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_operand = x; bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); lat = 1;
    @(negedge clk); bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    repeat (hold) @(negedge clk);
    d = bus.out_data; c = bus.out_c; v = bus.out_v; z = bus.out_z;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_op = LOAD; bus.in_operand = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if ({A, B, Carry_in} !== '0) begin errors++; $display("FAIL rst_adder_ports got A=%h B=%h ci=%b exp 0", A, B, Carry_in); end
    checks++; if ({bus.out_data, bus.out_c, bus.out_v, bus.out_z} !== '0)
      begin errors++; $display("FAIL rst_outputs got d=%h c%b v%b z%b exp 0", bus.out_data, bus.out_c, bus.out_v, bus.out_z); end
    rst = 1'b0; m_acc = '0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", bus.in_ready); end
  endtask

  typedef struct { calc_op_e op; logic [N-1:0] x; logic [N-1:0] d; logic c, v, z; } vec_t;

  task automatic test_directed();
    vec_t t[9];
    logic [N-1:0] d, md; logic c, v, z, mc, mv, mz; int lat;
    t[0] = '{LOAD, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0};
    t[1] = '{ADD,  8'hF0, SAT ? 8'hFF : 8'h2C, 1'b1, 1'b0, 1'b0};
    t[2] = '{LOAD, 8'h2C, 8'h2C, 1'b0, 1'b0, 1'b0};
    t[3] = '{SUB,  8'h2C, 8'h00, 1'b0, 1'b0, 1'b1};
    t[4] = '{SUB,  8'h01, SAT ? 8'h00 : 8'hFF, 1'b1, 1'b0, SAT};
    t[5] = '{LOAD, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0};
    t[6] = '{ADD,  8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    t[7] = '{CLR,  8'h5A, 8'h00, 1'b0, 1'b0, 1'b1};
    t[8] = '{ADD,  8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      do_op(t[i].op, t[i].x, 0, d, c, v, z, lat);
      model(t[i].op, t[i].x, md, mc, mv, mz);
      checks++; if (lat !== 2) begin errors++; $display("FAIL dir%0d_latency got %0d exp 2", i, lat); end
      checks++; if ({d, c, v, z} !== {t[i].d, t[i].c, t[i].v, t[i].z})
        begin errors++; $display("FAIL dir%0d_result got d=%h c%b v%b z%b exp d=%h c%b v%b z%b",
                                 i, d, c, v, z, t[i].d, t[i].c, t[i].v, t[i].z); end
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] md; logic mc, mv, mz; int n;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = LOAD; bus.in_operand = 8'hA5; bus.out_ready = 1'b0;
    model(LOAD, 8'hA5, md, mc, mv, mz);
    @(posedge clk);
    @(negedge clk); bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    bus.in_valid = 1'b1; bus.in_op = ADD; bus.in_operand = 8'h11;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_c, bus.out_v, bus.out_z} !== {1'b1, 1'b0, md, mc, mv, mz})
        begin errors++; $display("FAIL stall%0d got vld%b rdy%b d=%h c%b v%b z%b exp vld1 rdy0 d=%h c%b v%b z%b", i,
                                 bus.out_valid, bus.in_ready, bus.out_data, bus.out_c, bus.out_v, bus.out_z, md, mc, mv, mz); end
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); bus.out_ready = 1'b0;
    checks++; if ({bus.in_ready, A} !== {1'b1, m_acc})
      begin errors++; $display("FAIL stall_acc_kept got rdy%b A=%h exp rdy1 A=%h", bus.in_ready, A, m_acc); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] md; logic mc, mv, mz; int cnt;
    cnt = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = ADD; bus.in_operand = 8'h01; bus.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        cnt++;
        model(ADD, 8'h01, md, mc, mv, mz);
        checks++; if (bus.out_data !== md) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", cnt, bus.out_data, md); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (cnt !== 10) begin errors++; $display("FAIL b2b_issue_rate got %0d results exp 10", cnt); end
    @(negedge clk); @(negedge clk); bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] d, md, x; logic c, v, z, mc, mv, mz; int lat; calc_op_e op;
    for (int i = 0; i < 40; i++) begin
      op = calc_op_e'($urandom_range(0, 3));
      x  = N'($urandom);
      do_op(op, x, $urandom_range(0, 3), d, c, v, z, lat);
      model(op, x, md, mc, mv, mz);
      checks++; if ({lat == 2, d, c, v, z} !== {1'b1, md, mc, mv, mz})
        begin errors++; $display("FAIL rnd%0d op%0d x=%h got lat%0d d=%h c%b v%b z%b exp lat2 d=%h c%b v%b z%b",
                                 i, op, x, lat, d, c, v, z, md, mc, mv, mz); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] d; logic c, v, z; int lat;
    do_op(LOAD, 8'h10, 0, d, c, v, z, lat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = ADD; bus.in_operand = 8'h05;
    @(posedge clk);
    @(negedge clk); bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.out_valid, bus.in_ready} !== 2'b00)
      begin errors++; $display("FAIL rst_exec got vld%b rdy%b exp vld0 rdy0", bus.out_valid, bus.in_ready); end
    rst = 1'b0; m_acc = '0;
    @(negedge clk);
    checks++; if ({bus.in_ready, A, bus.out_z} !== {1'b1, 8'h00, 1'b0})
      begin errors++; $display("FAIL rst_exec_after got rdy%b A=%h z%b exp rdy1 A=00 z0", bus.in_ready, A, bus.out_z); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
